// File: rtl/snake_pkg.sv
// Shared constants and types for the score display path.
package snake_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

  typedef logic [3:0] bcd_digit_t;

  // Scan position, units first.
  typedef enum logic [1:0] {
    DIG_UNITS     = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_sel_e;

  // Active-low one-hot anode pattern for a scan position.
  function automatic logic [3:0] anode_for(input digit_sel_e sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD counter; clear wins over increment.
module bcd_counter4
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] bcd
);

  logic [15:0] bcd_q;
  logic [15:0] bcd_d;
  logic        carry;

  // Next count: clear, or ripple a +1 through the nibbles, holding at 9999.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    if (clr) begin
      bcd_d = '0;
    end else if (inc && (bcd_q != BCD_MAX)) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (bcd_q[i*4 +: 4] == 4'd9) begin
            bcd_d[i*4 +: 4] = 4'd0;
          end else begin
            bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_display_scan.sv
// Holds the BCD game score and time-multiplexes it onto four
// common-anode digits, with optional leading-zero blanking.
module score_display_scan
  import snake_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 16,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_inc,
  input  logic        score_clr,
  output logic [15:0] score_bcd,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  digit_sel_e              sel_q, sel_d;
  logic [3:0]              an_q, an_d;
  bcd_digit_t              digit_q, digit_d;
  logic [3:0]              zero_above;
  bcd_digit_t              nibble;

  bcd_counter4 u_counter (
    .clk (clk),
    .rst (rst),
    .inc (score_inc),
    .clr (score_clr),
    .bcd (score_bcd)
  );

  // Prescaler free-runs; sel advances when the prescaler wraps.
  always_comb begin
    presc_d = presc_q + REFRESH_BITS'(1);
    sel_d   = sel_q;
    if (&presc_q) begin
      sel_d = digit_sel_e'(sel_q + 2'd1);
    end
  end

  // Output select and blanking from the current sel and score.
  always_comb begin
    zero_above[3] = (score_bcd[15:12] == 4'd0);
    zero_above[2] = zero_above[3] && (score_bcd[11:8] == 4'd0);
    zero_above[1] = zero_above[2] && (score_bcd[7:4] == 4'd0);
    zero_above[0] = 1'b0;
    nibble        = score_bcd[{sel_q, 2'b00} +: 4];
    an_d          = anode_for(sel_q);
    digit_d       = nibble;
    if (BLANK_LZ && zero_above[sel_q]) begin
      digit_d = BLANK_CODE;
    end
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sel_q   <= DIG_UNITS;
      an_q    <= AN_ALL_OFF;
      digit_q <= BLANK_CODE;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign an    = an_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Randomized bench for score_display_scan against a decimal reference model.
module tb_score_display_scan;

  logic        clk;
  logic        rst;
  logic        score_inc;
  logic        score_clr;
  logic [15:0] score_bcd;
  logic [3:0]  digit;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: decimal score and cycles elapsed since reset.
  int m_score = 0;
  int m_cnt   = 0;
  logic [3:0] exp_an;
  logic [3:0] exp_digit;

  score_display_scan #(
    .REFRESH_BITS (2),
    .BLANK_LZ     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .score_bcd (score_bcd),
    .digit     (digit),
    .an        (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    int v;
    v = s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit k of score s, blank when the score has no digit that high.
  function automatic logic [3:0] ref_digit(input int s, input int k);
    int pw;
    pw = 1;
    for (int j = 0; j < k; j++) pw = pw * 10;
    if (k > 0 && s < pw) return 4'hF;
    return 4'((s / pw) % 10);
  endfunction

  function automatic int slot_of(input int cnt);
    return (cnt / 4) % 4;
  endfunction

  task automatic step(input logic r, input logic i, input logic c);
    int slot;
    rst       = r;
    score_inc = i;
    score_clr = c;
    @(posedge clk);
    if (r) begin
      m_score   = 0;
      m_cnt     = 0;
      exp_an    = 4'hF;
      exp_digit = 4'hF;
    end else begin
      slot      = slot_of(m_cnt);
      exp_an    = ~(4'(1) << slot);
      exp_digit = ref_digit(m_score, slot);
      m_cnt++;
      if (c) m_score = 0;
      else if (i && m_score < 9999) m_score++;
    end
    #1;
    check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("an", 32'(an), 32'(exp_an));
    check("digit", 32'(digit), 32'(exp_digit));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    score_inc = 1'b0;
    score_clr = 1'b0;

    // Reset, then a blanked zero scan.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(20);

    // Multi-digit count with carries.
    incs(1234);
    idle(16);

    // 0099 blanking, then 0999 -> 1000 carry chain.
    step(1'b0, 1'b0, 1'b1);
    incs(99);
    idle(16);
    incs(900);
    idle(16);
    incs(1);
    idle(16);

    // Saturation at 9999.
    incs(9000);
    incs(5);
    idle(16);

    // Clear takes priority over increment.
    step(1'b0, 1'b0, 1'b1);
    incs(42);
    step(1'b0, 1'b1, 1'b1);
    idle(16);

    // Reset while hundreds slot is selected.
    incs(375);
    for (int k = 0; k < 16 && slot_of(m_cnt) != 2; k++) step(1'b0, 1'b0, 1'b0);
    check("sel_reached_2", 32'(slot_of(m_cnt)), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    idle(20);

    // Random traffic including occasional clears and resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) == 0));
    end
    idle(16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
